ex_stage: RTL and testbench
===========================

# ex_stage

Execute stage of the five-stage pipeline, sitting between the ID/EX register and the memory stage. Computes ALU results, the six branch condition flags, and the branch and jump targets. Owns the HI/LO registers, with a single-cycle multiplier and an iterative 32-cycle divider that stalls upstream. Registers everything into the EX/MEM bundle that the memory stage consumes.

## Interface
Parameters:
- DIV_ITERS, 32, radix-2 divider iterations. Fixed at 32; the parameter exists only for bench shortening.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  reset; asynchronous, active-high
- id_ex_valid  in  1  instruction in ID/EX is real (not a bubble)
- id_ex_alu_op  in  5  operation code (ex_pkg encoding)
- id_ex_a, id_ex_b  in  32  forwarded rs/rt values
- id_ex_imm  in  32  sign/zero-extended immediate, already selected by decode
- id_ex_use_imm  in  1  1 = operand B is id_ex_imm
- id_ex_shamt  in  5  shift amount
- id_ex_pc_plus4  in  32  PC+4 of this instruction
- id_ex_jump_target  in  26  J-type target field
- id_ex_rd  in  5  destination register
- id_ex_ctrl  in  14  packed {branch, branch_type[2:0], jump, jump_reg, load_type[2:0], mem_to_reg, mem_write, reg_write, store_type[1:0]}
- flush  in  1  squash: branch_taken OR jump_taken from the memory stage
- ex_busy  out  1  stall request; upstream holds ID/EX and PC while high
- ex_mem_alu_out  out  32  result / memory address
- ex_mem_reg_b_data  out  32  id_ex_b, used as store data
- ex_mem_rd  out  5  destination register
- ex_mem_ctrl_*  out  —  the 14 control bits unpacked, same names and widths as in id_ex_ctrl
- ex_mem_alu_{beq,bne,bgez,bgtz,blez,bltz}_sig  out  1 each  branch flags
- ex_mem_pc_branch, ex_mem_pc_jump  out  32  branch and jump targets

## Operation
- ALU ops: add, sub (wraparound, no overflow trap), and, or, xor, nor, slt (signed), sltu, sll, srl, sra, sllv/srlv/srav (amount is a[4:0]), lui ({b[15:0],16'h0}), mfhi, mflo, mthi, mtlo, mult, multu, div, divu.
- Flags:
  - beq = (a==b); bne = ~beq.
  - bgez = ~a[31]; bltz = a[31].
  - bgtz = ~a[31] & |a; blez = ~bgtz.
- pc_branch = pc_plus4 + {imm[29:0],2'b00}.
- pc_jump = jump_reg ? a : {pc_plus4[31:28], jump_target, 2'b00}.
- mult/multu: 64-bit product; HI/LO are written at the edge where the instruction leaves EX. mthi/mtlo write a likewise.
- Divider FSM:
  - IDLE: a valid div/divu with no flush goes to DIV and latches operand magnitudes; count=0.
  - DIV: one restoring step per cycle; count++. After DIV_ITERS steps, go to DONE.
  - DONE: apply signs; HI=remainder, LO=quotient; return to IDLE.
- Signed divide: quotient is negative iff the operand signs differ; remainder takes the sign of the dividend.
- Divide by zero: LO=32'hFFFF_FFFF, HI=dividend. This is a defined result, not an exception.
- ex_busy = (IDLE & valid div op) | DIV. It is low in DONE.
- While ex_busy is high, EX/MEM loads a bubble (reg_write, mem_write, branch, jump, jump_reg all 0).
- flush:
  - EX/MEM loads a bubble.
  - The divider aborts to IDLE with HI/LO unchanged.
  - An mult/mthi/mtlo in EX is not committed.
  - Flush beats DONE in the same cycle: no HI/LO write.
- Reset clears all EX/MEM outputs, HI, LO, and count to 0, and sets the FSM to IDLE. Reset mid-divide discards the operation.

## Timing
- Non-divide ops: 1 cycle. Inputs in cycle n appear at the EX/MEM outputs after the edge ending cycle n.
- div issued in cycle 0:
  - ex_busy is high in cycles 0..32.
  - DONE is cycle 33. The div reaches EX/MEM and HI/LO after the edge ending cycle 33.
  - Occupancy is 34 cycles.
- mfhi/mflo in the cycle immediately after the producer leaves EX reads the new value. No bypass is needed.
- ex_busy is combinational from id_ex_alu_op and FSM state. It must not depend on flush.

## Structure
- ex_pkg:
  - ALU op encodings
  - BRANCH_BEQ..BRANCH_BNE = 0..5
  - bit-position constants for the id_ex_ctrl packing
  - divider FSM state encodings
- Sub-module iter_divider:
  - inputs: start, signed_op, dividend, divisor, abort
  - outputs: busy, done, quotient, remainder
- ALU, flags, targets, HI/LO and the EX/MEM register stay in ex_stage.

## Test plan
- add 7+(-3) -> alu_out 4. slt -1,1 -> 1. sltu -1,1 -> 0. sra 0x80000000 by 4 -> 0xF8000000.
- a=0, b=0 -> beq=1, bgez=1, blez=1, bgtz=0, bltz=0, bne=0. pc_plus4=0x100, imm=-1 -> pc_branch 0xFC.
- mult 0xFFFFFFFF×2 -> HI=0xFFFFFFFF, LO=0xFFFFFFFE. multu same operands -> HI=1, LO=0xFFFFFFFE. mfhi next cycle returns the new HI.
- div -7/2 -> ex_busy high for 33 cycles, then LO=-3, HI=-1. divu 7/0 -> LO=0xFFFFFFFF, HI=7.
- Flush at cycle 10 of a div -> ex_busy drops next cycle, HI/LO unchanged, EX/MEM holds a bubble.
- rst asserted mid-divide -> all outputs 0 asynchronously. After release, a new add completes in 1 cycle.

Source files
------------

// File: rtl/ex_pkg.sv
// Shared encodings for the execute stage: ALU opcodes, branch types, control-bundle
// bit positions and divider FSM states.
package ex_pkg;

  typedef enum logic [4:0] {
    AluAdd, AluSub, AluAnd, AluOr, AluXor, AluNor, AluSlt, AluSltu,
    AluSll, AluSrl, AluSra, AluSllv, AluSrlv, AluSrav, AluLui,
    AluMfhi, AluMflo, AluMthi, AluMtlo, AluMult, AluMultu, AluDiv, AluDivu
  } alu_op_e;

  localparam logic [2:0] BRANCH_BEQ  = 3'd0;
  localparam logic [2:0] BRANCH_BGEZ = 3'd1;
  localparam logic [2:0] BRANCH_BGTZ = 3'd2;
  localparam logic [2:0] BRANCH_BLEZ = 3'd3;
  localparam logic [2:0] BRANCH_BLTZ = 3'd4;
  localparam logic [2:0] BRANCH_BNE  = 3'd5;

  // {branch, branch_type[2:0], jump, jump_reg, load_type[2:0], mem_to_reg, mem_write,
  //  reg_write, store_type[1:0]}
  localparam int unsigned CtrlW         = 14;
  localparam int unsigned CtrlBranch    = 13;
  localparam int unsigned CtrlBrTypeLsb = 10;
  localparam int unsigned CtrlJump      = 9;
  localparam int unsigned CtrlJumpReg   = 8;
  localparam int unsigned CtrlLoadLsb   = 5;
  localparam int unsigned CtrlMemToReg  = 4;
  localparam int unsigned CtrlMemWrite  = 3;
  localparam int unsigned CtrlRegWrite  = 2;
  localparam int unsigned CtrlStoreLsb  = 0;

  typedef enum logic [1:0] {DivIdle, DivRun, DivDone} div_state_e;

  function automatic logic [31:0] mag32(input logic [31:0] v, input logic is_signed);
    return (is_signed && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/iter_divider.sv
// Radix-2 restoring divider: one quotient bit per cycle on operand magnitudes,
// signs and the divide-by-zero result applied combinationally in the done state.
module iter_divider
  import ex_pkg::*;
#(
  parameter int unsigned DIV_ITERS = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        signed_op,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  input  logic        abort,
  output logic        busy,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  localparam int unsigned CntW = $clog2(DIV_ITERS + 1);

  div_state_e      state_q, state_d;
  logic [CntW-1:0] count_q, count_d;
  logic [31:0]     rem_q, rem_d, quo_q, quo_d, dvsr_q, dvsr_d, dvd_q, dvd_d;
  logic            qneg_q, qneg_d, rneg_q, rneg_d, zero_q, zero_d;
  logic [32:0]     shifted, diff;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvsr_d  = dvsr_q;
    dvd_d   = dvd_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    zero_d  = zero_q;
    shifted = {rem_q, quo_q[31]};
    diff    = shifted - {1'b0, dvsr_q};
    case (state_q)
      DivIdle: begin
        if (start && !abort) begin
          state_d = DivRun;
          count_d = '0;
          rem_d   = '0;
          quo_d   = mag32(dividend, signed_op);
          dvsr_d  = mag32(divisor, signed_op);
          dvd_d   = dividend;
          qneg_d  = signed_op & (dividend[31] ^ divisor[31]);
          rneg_d  = signed_op & dividend[31];
          zero_d  = (divisor == 32'd0);
        end
      end
      DivRun: begin
        count_d = count_q + CntW'(1);
        // Bit 32 of diff set means the trial subtraction underflowed: restore.
        if (diff[32]) begin
          rem_d = shifted[31:0];
          quo_d = {quo_q[30:0], 1'b0};
        end else begin
          rem_d = diff[31:0];
          quo_d = {quo_q[30:0], 1'b1};
        end
        if (count_q == CntW'(DIV_ITERS - 1)) state_d = DivDone;
      end
      DivDone: state_d = DivIdle;
      default: state_d = DivIdle;
    endcase
    if (abort) state_d = DivIdle;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= DivIdle;
      count_q <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvsr_q  <= '0;
      dvd_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvsr_q  <= dvsr_d;
      dvd_q   <= dvd_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      zero_q  <= zero_d;
    end
  end

  assign busy      = ((state_q == DivIdle) && start) || (state_q == DivRun);
  assign done      = (state_q == DivDone);
  assign quotient  = zero_q ? 32'hFFFF_FFFF : (qneg_q ? (~quo_q + 32'd1) : quo_q);
  assign remainder = zero_q ? dvd_q : (rneg_q ? (~rem_q + 32'd1) : rem_q);

endmodule

// File: rtl/ex_stage.sv
// Execute stage: ALU, branch flags, branch/jump targets, HI/LO with single-cycle
// multiply and iterative divide, and the EX/MEM pipeline register.
module ex_stage
  import ex_pkg::*;
#(
  parameter int unsigned DIV_ITERS = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_ex_valid,
  input  logic [4:0]       id_ex_alu_op,
  input  logic [31:0]      id_ex_a,
  input  logic [31:0]      id_ex_b,
  input  logic [31:0]      id_ex_imm,
  input  logic             id_ex_use_imm,
  input  logic [4:0]       id_ex_shamt,
  input  logic [31:0]      id_ex_pc_plus4,
  input  logic [25:0]      id_ex_jump_target,
  input  logic [4:0]       id_ex_rd,
  input  logic [CtrlW-1:0] id_ex_ctrl,
  input  logic             flush,
  output logic             ex_busy,
  output logic [31:0]      ex_mem_alu_out,
  output logic [31:0]      ex_mem_reg_b_data,
  output logic [4:0]       ex_mem_rd,
  output logic             ex_mem_ctrl_branch,
  output logic [2:0]       ex_mem_ctrl_branch_type,
  output logic             ex_mem_ctrl_jump,
  output logic             ex_mem_ctrl_jump_reg,
  output logic [2:0]       ex_mem_ctrl_load_type,
  output logic             ex_mem_ctrl_mem_to_reg,
  output logic             ex_mem_ctrl_mem_write,
  output logic             ex_mem_ctrl_reg_write,
  output logic [1:0]       ex_mem_ctrl_store_type,
  output logic             ex_mem_alu_beq_sig,
  output logic             ex_mem_alu_bne_sig,
  output logic             ex_mem_alu_bgez_sig,
  output logic             ex_mem_alu_bgtz_sig,
  output logic             ex_mem_alu_blez_sig,
  output logic             ex_mem_alu_bltz_sig,
  output logic [31:0]      ex_mem_pc_branch,
  output logic [31:0]      ex_mem_pc_jump
);

  alu_op_e          op;
  logic [31:0]      op_b, alu_res, hi_q, hi_d, lo_q, lo_d, div_quo, div_rem;
  logic [31:0]      pc_branch, pc_jump;
  logic [63:0]      prod_s, prod_u;
  logic             is_div, div_busy, div_done, commit, kill, beq, bgtz;
  logic [5:0]       flags;
  logic [CtrlW-1:0] ctrl_d;

  logic [31:0]      alu_out_q, reg_b_q, pc_branch_q, pc_jump_q;
  logic [4:0]       rd_q;
  logic [CtrlW-1:0] ctrl_q;
  logic [5:0]       flags_q;

  assign op     = alu_op_e'(id_ex_alu_op);
  assign op_b   = id_ex_use_imm ? id_ex_imm : id_ex_b;
  assign is_div = id_ex_valid && ((op == AluDiv) || (op == AluDivu));

  iter_divider #(.DIV_ITERS(DIV_ITERS)) u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (is_div),
    .signed_op (op == AluDiv),
    .dividend  (id_ex_a),
    .divisor   (id_ex_b),
    .abort     (flush),
    .busy      (div_busy),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  assign ex_busy = div_busy;

  // Full 64x64 products keep the low 64 bits exact for both signednesses.
  assign prod_s = $signed({{32{id_ex_a[31]}}, id_ex_a}) * $signed({{32{id_ex_b[31]}}, id_ex_b});
  assign prod_u = {32'h0, id_ex_a} * {32'h0, id_ex_b};

  always_comb begin
    alu_res = '0;
    case (op)
      AluAdd:  alu_res = id_ex_a + op_b;
      AluSub:  alu_res = id_ex_a - op_b;
      AluAnd:  alu_res = id_ex_a & op_b;
      AluOr:   alu_res = id_ex_a | op_b;
      AluXor:  alu_res = id_ex_a ^ op_b;
      AluNor:  alu_res = ~(id_ex_a | op_b);
      AluSlt:  alu_res = {31'h0, $signed(id_ex_a) < $signed(op_b)};
      AluSltu: alu_res = {31'h0, id_ex_a < op_b};
      AluSll:  alu_res = op_b << id_ex_shamt;
      AluSrl:  alu_res = op_b >> id_ex_shamt;
      AluSra:  alu_res = $signed(op_b) >>> id_ex_shamt;
      AluSllv: alu_res = op_b << id_ex_a[4:0];
      AluSrlv: alu_res = op_b >> id_ex_a[4:0];
      AluSrav: alu_res = $signed(op_b) >>> id_ex_a[4:0];
      AluLui:  alu_res = {op_b[15:0], 16'h0};
      AluMfhi: alu_res = hi_q;
      AluMflo: alu_res = lo_q;
      default: alu_res = '0;
    endcase
  end

  assign commit = id_ex_valid && !flush && !div_busy;

  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (commit) begin
      case (op)
        AluMult:  {hi_d, lo_d} = prod_s;
        AluMultu: {hi_d, lo_d} = prod_u;
        AluMthi:  hi_d = id_ex_a;
        AluMtlo:  lo_d = id_ex_a;
        AluDiv, AluDivu: begin
          if (div_done) begin
            hi_d = div_rem;
            lo_d = div_quo;
          end
        end
        default: ;
      endcase
    end
  end

  assign beq       = (id_ex_a == id_ex_b);
  assign bgtz      = !id_ex_a[31] && (|id_ex_a);
  assign flags     = {beq, !beq, !id_ex_a[31], bgtz, !bgtz, id_ex_a[31]};
  assign pc_branch = id_ex_pc_plus4 + {id_ex_imm[29:0], 2'b00};
  assign pc_jump   = id_ex_ctrl[CtrlJumpReg] ? id_ex_a
                                             : {id_ex_pc_plus4[31:28], id_ex_jump_target, 2'b00};

  assign kill = flush || div_busy || !id_ex_valid;

  always_comb begin
    ctrl_d = id_ex_ctrl;
    if (kill) begin
      ctrl_d[CtrlRegWrite] = 1'b0;
      ctrl_d[CtrlMemWrite] = 1'b0;
      ctrl_d[CtrlBranch]   = 1'b0;
      ctrl_d[CtrlJump]     = 1'b0;
      ctrl_d[CtrlJumpReg]  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_q        <= '0;
      lo_q        <= '0;
      alu_out_q   <= '0;
      reg_b_q     <= '0;
      rd_q        <= '0;
      ctrl_q      <= '0;
      flags_q     <= '0;
      pc_branch_q <= '0;
      pc_jump_q   <= '0;
    end else begin
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      alu_out_q   <= alu_res;
      reg_b_q     <= id_ex_b;
      rd_q        <= id_ex_rd;
      ctrl_q      <= ctrl_d;
      flags_q     <= flags;
      pc_branch_q <= pc_branch;
      pc_jump_q   <= pc_jump;
    end
  end

  assign ex_mem_alu_out          = alu_out_q;
  assign ex_mem_reg_b_data       = reg_b_q;
  assign ex_mem_rd               = rd_q;
  assign ex_mem_ctrl_branch      = ctrl_q[CtrlBranch];
  assign ex_mem_ctrl_branch_type = ctrl_q[CtrlBrTypeLsb +: 3];
  assign ex_mem_ctrl_jump        = ctrl_q[CtrlJump];
  assign ex_mem_ctrl_jump_reg    = ctrl_q[CtrlJumpReg];
  assign ex_mem_ctrl_load_type   = ctrl_q[CtrlLoadLsb +: 3];
  assign ex_mem_ctrl_mem_to_reg  = ctrl_q[CtrlMemToReg];
  assign ex_mem_ctrl_mem_write   = ctrl_q[CtrlMemWrite];
  assign ex_mem_ctrl_reg_write   = ctrl_q[CtrlRegWrite];
  assign ex_mem_ctrl_store_type  = ctrl_q[CtrlStoreLsb +: 2];
  assign {ex_mem_alu_beq_sig, ex_mem_alu_bne_sig, ex_mem_alu_bgez_sig,
          ex_mem_alu_bgtz_sig, ex_mem_alu_blez_sig, ex_mem_alu_bltz_sig} = flags_q;
  assign ex_mem_pc_branch        = pc_branch_q;
  assign ex_mem_pc_jump          = pc_jump_q;

endmodule

// File: tb/tb_ex_stage.sv
// Directed self-checking bench for ex_stage: ALU, flags, targets, mult, divide timing,
// flush and asynchronous reset behaviour.
module tb_ex_stage;
  import ex_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_ex_valid, id_ex_use_imm, flush;
  logic [4:0]  id_ex_alu_op, id_ex_shamt, id_ex_rd;
  logic [31:0] id_ex_a, id_ex_b, id_ex_imm, id_ex_pc_plus4;
  logic [25:0] id_ex_jump_target;
  logic [13:0] id_ex_ctrl;
  logic        ex_busy;
  logic [31:0] ex_mem_alu_out, ex_mem_reg_b_data, ex_mem_pc_branch, ex_mem_pc_jump;
  logic [4:0]  ex_mem_rd;
  logic        ex_mem_ctrl_branch, ex_mem_ctrl_jump, ex_mem_ctrl_jump_reg;
  logic [2:0]  ex_mem_ctrl_branch_type, ex_mem_ctrl_load_type;
  logic        ex_mem_ctrl_mem_to_reg, ex_mem_ctrl_mem_write, ex_mem_ctrl_reg_write;
  logic [1:0]  ex_mem_ctrl_store_type;
  logic        beq_s, bne_s, bgez_s, bgtz_s, blez_s, bltz_s;

  int checks = 0;
  int errors = 0;

  ex_stage #(.DIV_ITERS(32)) dut (
    .clk                     (clk),
    .rst                     (rst),
    .id_ex_valid             (id_ex_valid),
    .id_ex_alu_op            (id_ex_alu_op),
    .id_ex_a                 (id_ex_a),
    .id_ex_b                 (id_ex_b),
    .id_ex_imm               (id_ex_imm),
    .id_ex_use_imm           (id_ex_use_imm),
    .id_ex_shamt             (id_ex_shamt),
    .id_ex_pc_plus4          (id_ex_pc_plus4),
    .id_ex_jump_target       (id_ex_jump_target),
    .id_ex_rd                (id_ex_rd),
    .id_ex_ctrl              (id_ex_ctrl),
    .flush                   (flush),
    .ex_busy                 (ex_busy),
    .ex_mem_alu_out          (ex_mem_alu_out),
    .ex_mem_reg_b_data       (ex_mem_reg_b_data),
    .ex_mem_rd               (ex_mem_rd),
    .ex_mem_ctrl_branch      (ex_mem_ctrl_branch),
    .ex_mem_ctrl_branch_type (ex_mem_ctrl_branch_type),
    .ex_mem_ctrl_jump        (ex_mem_ctrl_jump),
    .ex_mem_ctrl_jump_reg    (ex_mem_ctrl_jump_reg),
    .ex_mem_ctrl_load_type   (ex_mem_ctrl_load_type),
    .ex_mem_ctrl_mem_to_reg  (ex_mem_ctrl_mem_to_reg),
    .ex_mem_ctrl_mem_write   (ex_mem_ctrl_mem_write),
    .ex_mem_ctrl_reg_write   (ex_mem_ctrl_reg_write),
    .ex_mem_ctrl_store_type  (ex_mem_ctrl_store_type),
    .ex_mem_alu_beq_sig      (beq_s),
    .ex_mem_alu_bne_sig      (bne_s),
    .ex_mem_alu_bgez_sig     (bgez_s),
    .ex_mem_alu_bgtz_sig     (bgtz_s),
    .ex_mem_alu_blez_sig     (blez_s),
    .ex_mem_alu_bltz_sig     (bltz_s),
    .ex_mem_pc_branch        (ex_mem_pc_branch),
    .ex_mem_pc_jump          (ex_mem_pc_jump)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input alu_op_e op, input logic [31:0] a, input logic [31:0] b);
    id_ex_valid  = 1'b1;
    id_ex_alu_op = op;
    id_ex_a      = a;
    id_ex_b      = b;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; id_ex_valid = 1'b0; id_ex_alu_op = '0; id_ex_a = '0;
    id_ex_b = '0; id_ex_imm = '0; id_ex_use_imm = 1'b0; id_ex_shamt = '0;
    id_ex_pc_plus4 = '0; id_ex_jump_target = '0; id_ex_rd = '0; id_ex_ctrl = '0;
    tick(); tick();
    checks++;
    if ({ex_mem_alu_out, ex_mem_pc_branch, ex_mem_pc_jump} !== 96'h0 || ex_busy !== 1'b0) begin
      errors++; $display("FAIL reset_state: alu=%h pcb=%h busy=%b required 0", ex_mem_alu_out,
                         ex_mem_pc_branch, ex_busy);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_alu();
    id_ex_ctrl = 14'h0004; id_ex_rd = 5'd9;
    issue(AluAdd, 32'd7, 32'hFFFF_FFFD); tick();
    checks++;
    if (ex_mem_alu_out !== 32'd4 || ex_mem_rd !== 5'd9 || ex_mem_ctrl_reg_write !== 1'b1 ||
        ex_mem_reg_b_data !== 32'hFFFF_FFFD) begin
      errors++; $display("FAIL add: alu=%h rd=%0d rw=%b bdata=%h required 4/9/1/fffffffd",
                         ex_mem_alu_out, ex_mem_rd, ex_mem_ctrl_reg_write, ex_mem_reg_b_data);
    end
    issue(AluSlt, 32'hFFFF_FFFF, 32'd1); tick();
    checks++;
    if (ex_mem_alu_out !== 32'd1) begin
      errors++; $display("FAIL slt: got %h required 1", ex_mem_alu_out);
    end
    issue(AluSltu, 32'hFFFF_FFFF, 32'd1); tick();
    checks++;
    if (ex_mem_alu_out !== 32'd0) begin
      errors++; $display("FAIL sltu: got %h required 0", ex_mem_alu_out);
    end
    issue(AluSra, 32'd0, 32'h8000_0000); id_ex_shamt = 5'd4; tick();
    checks++;
    if (ex_mem_alu_out !== 32'hF800_0000) begin
      errors++; $display("FAIL sra: got %h required f8000000", ex_mem_alu_out);
    end
    issue(AluSrlv, 32'd4, 32'h8000_0000); tick();
    checks++;
    if (ex_mem_alu_out !== 32'h0800_0000) begin
      errors++; $display("FAIL srlv: got %h required 08000000", ex_mem_alu_out);
    end
    issue(AluNor, 32'd0, 32'hFF00_FF00); tick();
    checks++;
    if (ex_mem_alu_out !== 32'h00FF_00FF) begin
      errors++; $display("FAIL nor: got %h required 00ff00ff", ex_mem_alu_out);
    end
    issue(AluAdd, 32'd5, 32'h0000_DEAD); id_ex_imm = 32'd10; id_ex_use_imm = 1'b1; tick();
    checks++;
    if (ex_mem_alu_out !== 32'd15) begin
      errors++; $display("FAIL addi: got %h required 0000000f", ex_mem_alu_out);
    end
    issue(AluLui, 32'd0, 32'd0); id_ex_imm = 32'h0000_1234; tick();
    checks++;
    if (ex_mem_alu_out !== 32'h1234_0000) begin
      errors++; $display("FAIL lui: got %h required 12340000", ex_mem_alu_out);
    end
    id_ex_use_imm = 1'b0; id_ex_imm = '0; id_ex_ctrl = '0;
  endtask

  task automatic test_flags_targets();
    issue(AluAdd, 32'd0, 32'd0); id_ex_pc_plus4 = 32'h100; id_ex_imm = 32'hFFFF_FFFF; tick();
    checks++;
    if ({beq_s, bne_s, bgez_s, bgtz_s, blez_s, bltz_s} !== 6'b101010 ||
        ex_mem_pc_branch !== 32'h0000_00FC) begin
      errors++; $display("FAIL flags_zero: flags=%b pcb=%h required 101010/fc",
                         {beq_s, bne_s, bgez_s, bgtz_s, blez_s, bltz_s}, ex_mem_pc_branch);
    end
    issue(AluAdd, 32'd5, 32'd3); tick();
    checks++;
    if ({beq_s, bne_s, bgez_s, bgtz_s, blez_s, bltz_s} !== 6'b011100) begin
      errors++; $display("FAIL flags_pos: got %b required 011100",
                         {beq_s, bne_s, bgez_s, bgtz_s, blez_s, bltz_s});
    end
    issue(AluAdd, 32'h8000_0000, 32'h8000_0000); tick();
    checks++;
    if ({beq_s, bne_s, bgez_s, bgtz_s, blez_s, bltz_s} !== 6'b100011) begin
      errors++; $display("FAIL flags_neg: got %b required 100011",
                         {beq_s, bne_s, bgez_s, bgtz_s, blez_s, bltz_s});
    end
    issue(AluAdd, 32'h1234_5678, 32'd0); id_ex_pc_plus4 = 32'h1000_0004;
    id_ex_jump_target = 26'h3; id_ex_ctrl = 14'h0200; tick();
    checks++;
    if (ex_mem_pc_jump !== 32'h1000_000C || ex_mem_ctrl_jump !== 1'b1) begin
      errors++; $display("FAIL jump: pcj=%h j=%b required 1000000c/1", ex_mem_pc_jump,
                         ex_mem_ctrl_jump);
    end
    id_ex_ctrl = 14'h0300; tick();
    checks++;
    if (ex_mem_pc_jump !== 32'h1234_5678 || ex_mem_ctrl_jump_reg !== 1'b1) begin
      errors++; $display("FAIL jump_reg: pcj=%h jr=%b required 12345678/1", ex_mem_pc_jump,
                         ex_mem_ctrl_jump_reg);
    end
    id_ex_ctrl = 14'b1_101_0_0_011_1_1_1_10; tick();
    checks++;
    if ({ex_mem_ctrl_branch, ex_mem_ctrl_branch_type, ex_mem_ctrl_jump, ex_mem_ctrl_jump_reg,
         ex_mem_ctrl_load_type, ex_mem_ctrl_mem_to_reg, ex_mem_ctrl_mem_write,
         ex_mem_ctrl_reg_write, ex_mem_ctrl_store_type} !== 14'b1_101_0_0_011_1_1_1_10) begin
      errors++; $display("FAIL ctrl_unpack: br=%b bt=%b lt=%b st=%b", ex_mem_ctrl_branch,
                         ex_mem_ctrl_branch_type, ex_mem_ctrl_load_type, ex_mem_ctrl_store_type);
    end
    id_ex_ctrl = '0; id_ex_imm = '0; id_ex_pc_plus4 = '0; id_ex_jump_target = '0;
  endtask

  task automatic test_mult();
    issue(AluMult, 32'hFFFF_FFFF, 32'd2); tick();
    issue(AluMfhi, 32'd0, 32'd0); tick();
    checks++;
    if (ex_mem_alu_out !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL mult_hi: got %h required ffffffff", ex_mem_alu_out);
    end
    issue(AluMflo, 32'd0, 32'd0); tick();
    checks++;
    if (ex_mem_alu_out !== 32'hFFFF_FFFE) begin
      errors++; $display("FAIL mult_lo: got %h required fffffffe", ex_mem_alu_out);
    end
    issue(AluMultu, 32'hFFFF_FFFF, 32'd2); tick();
    issue(AluMfhi, 32'd0, 32'd0); tick();
    checks++;
    if (ex_mem_alu_out !== 32'd1) begin
      errors++; $display("FAIL multu_hi: got %h required 00000001", ex_mem_alu_out);
    end
    issue(AluMflo, 32'd0, 32'd0); tick();
    checks++;
    if (ex_mem_alu_out !== 32'hFFFF_FFFE) begin
      errors++; $display("FAIL multu_lo: got %h required fffffffe", ex_mem_alu_out);
    end
  endtask

  task automatic test_div();
    int busy_cycles;
    issue(AluDiv, 32'hFFFF_FFF9, 32'd2); id_ex_ctrl = 14'h0004; #1;
    busy_cycles = 0;
    while (ex_busy === 1'b1 && busy_cycles < 50) begin
      busy_cycles++;
      tick();
    end
    checks++;
    if (busy_cycles !== 33) begin
      errors++; $display("FAIL div_busy_len: got %0d cycles required 33", busy_cycles);
    end
    checks++;
    if (ex_mem_ctrl_reg_write !== 1'b0) begin
      errors++; $display("FAIL div_bubble: reg_write=%b required 0", ex_mem_ctrl_reg_write);
    end
    tick();
    checks++;
    if (ex_mem_ctrl_reg_write !== 1'b1) begin
      errors++; $display("FAIL div_leaves: reg_write=%b required 1", ex_mem_ctrl_reg_write);
    end
    id_ex_ctrl = '0;
    issue(AluMflo, 32'd0, 32'd0); tick();
    checks++;
    if (ex_mem_alu_out !== 32'hFFFF_FFFD) begin
      errors++; $display("FAIL div_lo: got %h required fffffffd", ex_mem_alu_out);
    end
    issue(AluMfhi, 32'd0, 32'd0); tick();
    checks++;
    if (ex_mem_alu_out !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL div_hi: got %h required ffffffff", ex_mem_alu_out);
    end
    issue(AluDivu, 32'd7, 32'd0); #1;
    busy_cycles = 0;
    while (ex_busy === 1'b1 && busy_cycles < 50) begin
      busy_cycles++;
      tick();
    end
    tick();
    issue(AluMflo, 32'd0, 32'd0); tick();
    checks++;
    if (ex_mem_alu_out !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL divu0_lo: got %h required ffffffff", ex_mem_alu_out);
    end
    issue(AluMfhi, 32'd0, 32'd0); tick();
    checks++;
    if (ex_mem_alu_out !== 32'd7) begin
      errors++; $display("FAIL divu0_hi: got %h required 00000007", ex_mem_alu_out);
    end
  endtask

  task automatic test_flush();
    int busy_cycles;
    issue(AluMthi, 32'h1111, 32'd0); tick();
    issue(AluMtlo, 32'h2222, 32'd0); tick();
    issue(AluDiv, 32'd100, 32'd7); id_ex_ctrl = 14'h0004;
    repeat (10) tick();
    checks++;
    if (ex_busy !== 1'b1) begin
      errors++; $display("FAIL flush_prebusy: busy=%b required 1", ex_busy);
    end
    flush = 1'b1; tick();
    flush = 1'b0; id_ex_valid = 1'b0; #1;
    checks++;
    if (ex_busy !== 1'b0 || ex_mem_ctrl_reg_write !== 1'b0) begin
      errors++; $display("FAIL flush_abort: busy=%b rw=%b required 0/0", ex_busy,
                         ex_mem_ctrl_reg_write);
    end
    issue(AluMult, 32'd3, 32'd3); flush = 1'b1; tick();
    flush = 1'b0; id_ex_ctrl = '0;
    issue(AluMfhi, 32'd0, 32'd0); tick();
    checks++;
    if (ex_mem_alu_out !== 32'h1111) begin
      errors++; $display("FAIL flush_hi: got %h required 00001111", ex_mem_alu_out);
    end
    issue(AluMflo, 32'd0, 32'd0); tick();
    checks++;
    if (ex_mem_alu_out !== 32'h2222) begin
      errors++; $display("FAIL flush_lo: got %h required 00002222", ex_mem_alu_out);
    end
    // Flush arriving in the done cycle must still block the HI/LO write.
    issue(AluDivu, 32'd9, 32'd3); #1;
    busy_cycles = 0;
    while (ex_busy === 1'b1 && busy_cycles < 50) begin
      busy_cycles++;
      tick();
    end
    flush = 1'b1; tick();
    flush = 1'b0;
    issue(AluMflo, 32'd0, 32'd0); tick();
    checks++;
    if (ex_mem_alu_out !== 32'h2222) begin
      errors++; $display("FAIL flush_done_lo: got %h required 00002222", ex_mem_alu_out);
    end
  endtask

  task automatic test_reset_mid_div();
    issue(AluDiv, 32'd50, 32'd5); id_ex_pc_plus4 = 32'h200; id_ex_imm = 32'd1; id_ex_rd = 5'd3;
    repeat (5) tick();
    checks++;
    if (ex_mem_pc_branch !== 32'h204 || ex_mem_rd !== 5'd3) begin
      errors++; $display("FAIL prereset: pcb=%h rd=%0d required 204/3", ex_mem_pc_branch,
                         ex_mem_rd);
    end
    #2;
    rst = 1'b1; id_ex_valid = 1'b0; #1;
    checks++;
    if (ex_mem_pc_branch !== 32'h0 || ex_mem_rd !== 5'd0 || ex_busy !== 1'b0) begin
      errors++; $display("FAIL async_reset: pcb=%h rd=%0d busy=%b required 0", ex_mem_pc_branch,
                         ex_mem_rd, ex_busy);
    end
    tick();
    rst = 1'b0; id_ex_pc_plus4 = '0; id_ex_imm = '0;
    issue(AluMfhi, 32'd0, 32'd0); tick();
    checks++;
    if (ex_mem_alu_out !== 32'h0) begin
      errors++; $display("FAIL reset_hi: got %h required 0", ex_mem_alu_out);
    end
    issue(AluAdd, 32'd7, 32'hFFFF_FFFD); tick();
    checks++;
    if (ex_mem_alu_out !== 32'd4 || ex_busy !== 1'b0) begin
      errors++; $display("FAIL post_reset_add: got %h busy=%b required 4/0", ex_mem_alu_out,
                         ex_busy);
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_flags_targets();
    test_mult();
    test_div();
    test_flush();
    test_reset_mid_div();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
